pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Sequencing controller for the decode→exec/dmem→writeback pipeline.
- Keeps a per-register pending-write scoreboard and stalls decode issue on RAW hazards.
- Turns exec-stage branch/jump redirects into a registered fetch-PC load plus a timed front-end flush.
- Drains the pipeline and enters a halt state when an ECALL/EBREAK is issued.

Parameters:
NUM_REGS, 32, general-register count; x0 is never tracked.
REG_IDX_W, 5, register index width; must equal clog2(NUM_REGS).
XLEN, 32, PC width.
FLUSH_CYCLES, 2, cycles the fetch/decode flush is held after a redirect; legal range 1..7.

Ports:
clk  in  1  clock.
rst  in  1  reset.
dec_valid  in  1  decode holds an instruction.
dec_rs1  in  REG_IDX_W  source 1 index.
dec_rs2  in  REG_IDX_W  source 2 index.
dec_rd  in  REG_IDX_W  destination index.
dec_uses_rs1  in  1  instruction reads rs1.
dec_uses_rs2  in  1  instruction reads rs2.
dec_writes_rd  in  1  instruction writes rd.
dec_halt  in  1  instruction is ECALL/EBREAK.
issue_ready  out  1  decode may advance; issue = dec_valid & issue_ready.
wb_valid  in  1  writeback retires a register write.
wb_rd  in  REG_IDX_W  retired destination.
redirect_valid  in  1  exec resolved a taken branch, JAL or JALR.
redirect_pc  in  XLEN  target PC.
fetch_pc_load  out  1  fetch loads fetch_pc this cycle.
fetch_pc  out  XLEN  registered redirect target.
flush_front  out  1  squash fetch and decode contents.
halted  out  1  core halted.
busy  out  1  scoreboard non-empty.

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: state=RUN, scoreboard=0, flush counter=0, fetch_pc=0. Outputs: fetch_pc_load=0, flush_front=0, halted=0, busy=0.
- Reset asserted mid-flush or mid-drain aborts immediately. No pending redirect survives reset.

Scoreboard:
- One pending bit per register.
- Set on issue when dec_writes_rd=1 and dec_rd!=0.
- Cleared on wb_valid for wb_rd.
- Set and clear of the same register in the same cycle: set wins.
- Writes targeting x0 are ignored.
- busy = OR of all pending bits.

Hazard:
- hazard = (dec_uses_rs1 & pending[rs1]) | (dec_uses_rs2 & pending[rs2]). x0 never hazards.
- No bypass: a writeback in cycle N unblocks issue in cycle N+1 (registered bit).

FSM:
- RUN:
  - issue_ready = !hazard & !redirect_valid.
  - redirect_valid → FLUSH and counter=FLUSH_CYCLES-1.
  - Else if issue & dec_halt → DRAIN.
- FLUSH:
  - issue_ready=0, flush_front=1.
  - Counter decrements each cycle; at 0 → RUN.
  - A new redirect_valid reloads the counter and updates fetch_pc.
- DRAIN:
  - issue_ready=0.
  - When busy=0 → HALT.
  - redirect_valid in DRAIN → FLUSH; the halt is cancelled.
- HALT:
  - halted=1, issue_ready=0.
  - Left only by rst.

Redirect timing:
- redirect_valid in cycle N: fetch_pc<=redirect_pc and fetch_pc_load=1 in cycle N+1, for exactly one cycle.
- flush_front is high from N+1 for FLUSH_CYCLES cycles.
- The instruction in decode in cycle N is never issued. Redirect beats halt in the same cycle.
- wb_valid is processed in every state, including HALT.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds outputs perf_stall_cnt (32), perf_flush_cnt (32) and perf_issue_cnt (32).
  - Stall counter counts cycles with dec_valid & !issue_ready in RUN.
  - Flush counter counts redirect_valid events.
  - Issue counter counts issues.
  - All reset to 0 and wrap at 2^32.
- Undefined: none of these ports or counters exist; all other behaviour is identical.

Decomposition:
- Package defs gets:
  - ctrl_state_e enum {RUN, FLUSH, DRAIN, HALT}.
  - Constants REG_X0=0 and FLUSH_CYCLES_DEFAULT=2.
- One sub-module, pipe_scoreboard, holds the pending bits, set/clear priority, the two hazard lookups and busy.
- The FSM and redirect register stay in pipeline_ctrl.

Test Plan:
- RAW stall: issue ADDI x5 (writes x5); next instruction reads rs1=x5 → issue_ready=0 until wb_valid, wb_rd=5 in cycle N; issue_ready=1 in N+1.
- x0 and same-cycle priority: issue writing rd=0 → busy stays 0. Issue rd=7 in the same cycle as wb_rd=7 → pending[7]=1.
- Redirect: redirect_valid, redirect_pc=0x0000_0100 in cycle 10 →
  - fetch_pc_load=1 and fetch_pc=0x100 in cycle 11 only;
  - flush_front=1 in cycles 11-12 (FLUSH_CYCLES=2);
  - no issue in cycles 10-12.
- Back-to-back redirects: second redirect to 0x200 during FLUSH → fetch_pc=0x200, flush extended 2 cycles from the reload.
- Halt drain: x3 pending, issue with dec_halt=1 → DRAIN. wb_rd=3 → halted=1 in the next cycle; rst pulse asynchronously clears halted.
- Perf counters (macro on): 3 stall cycles, 1 redirect, 4 issues → counters read 3/1/4.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared FSM state type and constants for the pipeline controller.
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALT} ctrl_state_e;
  localparam int REG_X0 = 0;
  localparam int FLUSH_CYCLES_DEFAULT = 2;
endpackage

// File: rtl/pipeline_ctrl_scoreboard.sv
// pipe_scoreboard: per-register pending-write bits, set-over-clear update, RAW lookups and busy.
module pipe_scoreboard
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic                 uses_rs1,
  input  logic                 uses_rs2,
  output logic                 hazard,
  output logic                 busy,
  output logic                 busy_next
);
  logic [NUM_REGS-1:0] pending_q, pending_d, set_mask, clr_mask;
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    set_mask[set_idx] = set_en && (set_idx != REG_IDX_W'(REG_X0));
    clr_mask[clr_idx] = clr_en;
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) pending_q <= '0;
    else pending_q <= pending_d;
  // x0 is never set, so its lookup can never report a hazard
  assign hazard = (uses_rs1 & pending_q[rs1]) | (uses_rs2 & pending_q[rs2]);
  assign busy = |pending_q;
  assign busy_next = |pending_d;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: RAW issue stall, redirect/flush sequencing and halt drain.
// Define PIPE_CTRL_PERF_EN to add stall/flush/issue performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int REG_IDX_W    = 5,
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  input  logic [REG_IDX_W-1:0] dec_rs1,
  input  logic [REG_IDX_W-1:0] dec_rs2,
  input  logic [REG_IDX_W-1:0] dec_rd,
  input  logic                 dec_uses_rs1,
  input  logic                 dec_uses_rs2,
  input  logic                 dec_writes_rd,
  input  logic                 dec_halt,
  output logic                 issue_ready,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 fetch_pc_load,
  output logic [XLEN-1:0]      fetch_pc,
  output logic                 flush_front,
  output logic                 halted,
  output logic                 busy
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt,
  output logic [31:0]          perf_issue_cnt
`endif
);
  ctrl_state_e     state_q;
  logic [2:0]      cnt_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic            fetch_pc_load_q, hazard, busy_next, issue, redir;
  pipe_scoreboard #(.NUM_REGS(NUM_REGS), .REG_IDX_W(REG_IDX_W)) u_sb (
    .clk(clk), .rst(rst),
    .set_en(issue & dec_writes_rd), .set_idx(dec_rd),
    .clr_en(wb_valid), .clr_idx(wb_rd),
    .rs1(dec_rs1), .rs2(dec_rs2),
    .uses_rs1(dec_uses_rs1), .uses_rs2(dec_uses_rs2),
    .hazard(hazard), .busy(busy), .busy_next(busy_next)
  );
  assign issue_ready = (state_q == RUN) & !hazard & !redirect_valid;
  assign issue = dec_valid & issue_ready;
  assign redir = redirect_valid & (state_q != HALT);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RUN;
      cnt_q <= '0;
      fetch_pc_q <= '0;
      fetch_pc_load_q <= 1'b0;
    end else begin
      fetch_pc_load_q <= redir;
      if (redir) begin
        fetch_pc_q <= redirect_pc;
        state_q <= FLUSH;
        cnt_q <= 3'(FLUSH_CYCLES - 1);
      end else
        case (state_q)
          RUN: if (issue & dec_halt) state_q <= DRAIN;
          FLUSH: if (cnt_q == 3'd0) state_q <= RUN; else cnt_q <= cnt_q - 3'd1;
          // halt as soon as this cycle's writeback empties the scoreboard
          DRAIN: if (!busy_next) state_q <= HALT;
          default: ;
        endcase
    end
  assign fetch_pc_load = fetch_pc_load_q;
  assign fetch_pc = fetch_pc_q;
  assign flush_front = state_q == FLUSH;
  assign halted = state_q == HALT;
`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_issue_cnt <= '0;
    end else begin
      if (state_q == RUN && dec_valid && !issue_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redir) perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (issue) perf_issue_cnt <= perf_issue_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed test-plan scenarios plus randomized traffic against a behavioural model.
module tb_pipeline_ctrl;
  localparam int FC = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic dec_valid, dec_uses_rs1, dec_uses_rs2, dec_writes_rd, dec_halt, wb_valid, redirect_valid;
  logic [4:0] dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic [31:0] redirect_pc, fetch_pc;
  logic issue_ready, fetch_pc_load, flush_front, halted, busy;
  int n_chk = 0, n_pass = 0;
  bit pend [32];
  int flush_left;
  bit draining, halt_m, load_m;
  logic [31:0] pc_m;
  pipeline_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .dec_writes_rd(dec_writes_rd), .dec_halt(dec_halt), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_pc_load(fetch_pc_load), .fetch_pc(fetch_pc), .flush_front(flush_front),
    .halted(halted), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic set(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                     input logic u1, input logic u2, input logic w, input logic h,
                     input logic wv, input logic [4:0] wr, input logic rv, input logic [31:0] pc);
    dec_valid = v; dec_rs1 = r1; dec_rs2 = r2; dec_rd = d;
    dec_uses_rs1 = u1; dec_uses_rs2 = u2; dec_writes_rd = w; dec_halt = h;
    wb_valid = wv; wb_rd = wr; redirect_valid = rv; redirect_pc = pc;
  endtask
  task automatic idle();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic model_reset();
    foreach (pend[i]) pend[i] = 0;
    flush_left = 0; draining = 0; halt_m = 0; load_m = 0; pc_m = 0;
  endtask
  // Applied at a negedge: asserts rst, checks its effect before any clock edge, releases it.
  task automatic do_reset();
    rst = 1'b1;
    idle();
    #1;
    check("rst_halted", {31'd0, halted}, 0);
    check("rst_flush", {31'd0, flush_front}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_load", {31'd0, fetch_pc_load}, 0);
    check("rst_pc", fetch_pc, 0);
    model_reset();
    rst = 1'b0;
  endtask
  // Compare DUT against the model for the current inputs, advance the model, move to next negedge.
  task automatic step();
    bit any, haz, ready, iss;
    #1;
    any = 0;
    foreach (pend[i]) any |= pend[i];
    haz = (dec_uses_rs1 && pend[dec_rs1]) || (dec_uses_rs2 && pend[dec_rs2]);
    ready = flush_left == 0 && !draining && !halt_m && !haz && !redirect_valid;
    iss = dec_valid && ready;
    check("issue_ready", {31'd0, issue_ready}, {31'd0, ready});
    check("flush_front", {31'd0, flush_front}, {31'd0, flush_left > 0});
    check("halted", {31'd0, halted}, {31'd0, halt_m});
    check("busy", {31'd0, busy}, {31'd0, any});
    check("pc_load", {31'd0, fetch_pc_load}, {31'd0, load_m});
    check("fetch_pc", fetch_pc, pc_m);
    if (wb_valid) pend[wb_rd] = 0;
    if (iss && dec_writes_rd && dec_rd != 0) pend[dec_rd] = 1;
    any = 0;
    foreach (pend[i]) any |= pend[i];
    load_m = redirect_valid && !halt_m;
    if (load_m) begin
      pc_m = redirect_pc; flush_left = FC; draining = 0;
    end else if (flush_left > 0) flush_left--;
    else if (draining) begin
      if (!any) begin halt_m = 1; draining = 0; end
    end else if (iss && dec_halt) draining = 1;
    @(negedge clk);
  endtask
  initial begin
    int halt_run;
    idle();
    @(negedge clk);
    do_reset();
    // RAW stall released the cycle after writeback
    set(1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 0, 0); step();
    set(1, 5, 0, 6, 1, 0, 1, 0, 0, 0, 0, 0); #1 check("raw_stall", {31'd0, issue_ready}, 0); step();
    set(1, 5, 0, 6, 1, 0, 1, 0, 1, 5, 0, 0); #1 check("raw_no_bypass", {31'd0, issue_ready}, 0); step();
    set(1, 5, 0, 6, 1, 0, 1, 0, 0, 0, 0, 0); #1 check("raw_clear", {31'd0, issue_ready}, 1); step();
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0); step();
    // x0 ignored, set beats clear
    set(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); step();
    idle(); #1 check("x0_busy", {31'd0, busy}, 0); step();
    set(1, 0, 0, 7, 0, 0, 1, 0, 1, 7, 0, 0); step();
    set(1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); #1 check("set_wins", {31'd0, issue_ready}, 0); step();
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0); step();
    // redirect timing
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100); #1 check("redir_noissue", {31'd0, issue_ready}, 0); step();
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1 check("redir_load", {31'd0, fetch_pc_load}, 1);
    check("redir_pc", fetch_pc, 32'h100); check("redir_ready1", {31'd0, issue_ready}, 0); step();
    #1 check("redir_load_once", {31'd0, fetch_pc_load}, 0); check("redir_flush2", {31'd0, flush_front}, 1); step();
    #1 check("redir_flush_end", {31'd0, flush_front}, 0); check("redir_resume", {31'd0, issue_ready}, 1); step();
    // back-to-back redirects
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100); step();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200); step();
    idle(); #1 check("b2b_pc", fetch_pc, 32'h200); check("b2b_load", {31'd0, fetch_pc_load}, 1); step();
    #1 check("b2b_flush_ext", {31'd0, flush_front}, 1); step();
    #1 check("b2b_flush_end", {31'd0, flush_front}, 0); step();
    // halt drain then asynchronous reset
    set(1, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0); step();
    set(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); #1 check("halt_issue", {31'd0, issue_ready}, 1); step();
    set(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1 check("drain_block", {31'd0, issue_ready}, 0); step();
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0); #1 check("drain_not_halted", {31'd0, halted}, 0); step();
    idle(); #1 check("halted_set", {31'd0, halted}, 1); step();
    do_reset();
    // randomized traffic
    halt_run = 0;
    for (int i = 0; i < 4000; i++) begin
      halt_run = halt_m ? halt_run + 1 : 0;
      if (halt_run > 4 || $urandom_range(0, 299) == 0) do_reset();
      set($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 47) == 0, 1'($urandom), 5'($urandom_range(0, 7)),
          $urandom_range(0, 11) == 0, $urandom);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
